// File: rtl/cond_unit.sv
// Branch/predicate condition evaluator: selects a predicate from the ALU flags
// or a signed compare of r2/r3, and registers it as t with one cycle of latency.
module cond_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        n,
    input  logic        z,
    input  logic        c,
    input  logic        v,
    input  logic [31:0] r2,
    input  logic [31:0] r3,
    input  logic [3:0]  cond,
    output logic        t
);

    typedef enum logic [3:0] {
        CC_NEVER  = 4'b0000,
        CC_EQ     = 4'b0001,
        CC_GT     = 4'b0010,
        CC_LT     = 4'b0011,
        CC_NE     = 4'b0100,
        CC_GE     = 4'b0101,
        CC_HI     = 4'b0110,
        CC_CS     = 4'b0111,
        CC_CC     = 4'b1000,
        CC_ALWAYS = 4'b1001,
        CC_MI     = 4'b1010,
        CC_PL     = 4'b1011,
        CC_VS     = 4'b1100,
        CC_VC     = 4'b1101,
        CC_LE     = 4'b1110,
        CC_RSVD   = 4'b1111
    } cond_e;

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic               p;
    logic               t_p0;

    assign a_s = $signed(r2);
    assign b_s = $signed(r3);

    // Each arm reads only the inputs its condition needs, so unknowns on
    // unused inputs cannot reach the predicate.
    always_comb begin
        p = 1'b0;
        case (cond_e'(cond))
            CC_NEVER:  p = 1'b0;
            CC_EQ:     p = (a_s == b_s);
            CC_GT:     p = (a_s >  b_s);
            CC_LT:     p = (a_s <  b_s);
            CC_NE:     p = (a_s != b_s);
            CC_GE:     p = (a_s >= b_s);
            CC_HI:     p = c & ~z;
            CC_CS:     p = c;
            CC_CC:     p = ~c;
            CC_ALWAYS: p = 1'b1;
            CC_MI:     p = n;
            CC_PL:     p = ~n;
            CC_VS:     p = v;
            CC_VC:     p = ~v;
            CC_LE:     p = (a_s <= b_s);
            CC_RSVD:   p = 1'b0;
            default:   p = 1'b0;
        endcase
    end

    // Stage p0: registered predicate
    always_ff @(posedge clk) begin
        if (rst) begin
            t_p0 <= 1'b0;
        end else begin
            t_p0 <= p;
        end
    end

    assign t = t_p0;

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: directed vectors push expected t values,
// a monitor pops and compares one edge after each vector is captured.
module tb_cond_unit;

    logic        clk;
    logic        rst;
    logic        n, z, c, v;
    logic [31:0] r2, r3;
    logic [3:0]  cond;
    logic        t;

    typedef struct {
        logic  exp;
        string name;
    } sb_entry_t;

    sb_entry_t sb[$];
    sb_entry_t ent;
    int tests  = 0;
    int failed = 0;

    cond_unit dut (
        .clk  (clk),
        .rst  (rst),
        .n    (n),
        .z    (z),
        .c    (c),
        .v    (v),
        .r2   (r2),
        .r3   (r3),
        .cond (cond),
        .t    (t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: t reflects the vector captured at the edge just passed.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            ent = sb.pop_front();
            tests++;
            if (t !== ent.exp) begin
                failed++;
                $display("FAIL %s: t=%b expected %b", ent.name, t, ent.exp);
            end
        end
    end

    task automatic apply(input logic r, input logic [3:0] cd,
                         input logic nn, input logic zz, input logic cc, input logic vv,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic e, input string nm);
        sb_entry_t s;
        @(negedge clk);
        rst  = r;
        cond = cd;
        n    = nn;
        z    = zz;
        c    = cc;
        v    = vv;
        r2   = a;
        r3   = b;
        s.exp  = e;
        s.name = nm;
        sb.push_back(s);
    endtask

    // Register compare helper: flags held at a mixed pattern to show they are ignored
    task automatic rc(input logic [3:0] cd, input logic [31:0] a, input logic [31:0] b,
                      input logic e, input string nm);
        apply(1'b0, cd, 1'b1, 1'b1, 1'b0, 1'b1, a, b, e, nm);
    endtask

    // Flag condition helper: operands held unequal to show they are ignored
    task automatic fc(input logic [3:0] cd, input logic nn, input logic zz,
                      input logic cc, input logic vv, input logic e, input string nm);
        apply(1'b0, cd, nn, zz, cc, vv, 32'h1234_5678, 32'h0000_0042, e, nm);
    endtask

    initial begin
        int guard;
        rst = 1'b1; cond = 4'b1001; n = 0; z = 0; c = 0; v = 0;
        r2 = 32'h0; r3 = 32'h0;

        // Reset with ALWAYS selected, then release
        apply(1'b1, 4'b1001, 0, 0, 0, 0, 32'h0, 32'h0, 1'b0, "reset_edge1");
        apply(1'b1, 4'b1001, 1, 1, 1, 1, 32'h5, 32'h5, 1'b0, "reset_edge2");
        apply(1'b0, 4'b1001, 0, 0, 0, 0, 32'h0, 32'h0, 1'b1, "reset_release");

        // Constants
        apply(1'b0, 4'b0000, 1, 1, 1, 1, 32'h1, 32'h1, 1'b0, "never");
        apply(1'b0, 4'b1001, 0, 0, 0, 0, 32'h1, 32'h2, 1'b1, "always");
        apply(1'b0, 4'b1111, 1, 1, 1, 1, 32'h1, 32'h1, 1'b0, "reserved_ones");
        apply(1'b0, 4'b1111, 0, 0, 0, 0, 32'h0, 32'h7, 1'b0, "reserved_zeros");

        // Equality set
        rc(4'b0001, 32'd1, 32'd1, 1'b1, "eq_1_1");
        rc(4'b0100, 32'd1, 32'd1, 1'b0, "ne_1_1");
        rc(4'b0101, 32'd1, 32'd1, 1'b1, "ge_1_1");
        rc(4'b0010, 32'd1, 32'd1, 1'b0, "gt_1_1");
        rc(4'b0011, 32'd1, 32'd1, 1'b0, "lt_1_1");
        rc(4'b1110, 32'd1, 32'd1, 1'b1, "le_1_1");
        rc(4'b0001, 32'd1, 32'd0, 1'b0, "eq_1_0");
        rc(4'b0100, 32'd1, 32'd0, 1'b1, "ne_1_0");
        rc(4'b0101, 32'd1, 32'd0, 1'b1, "ge_1_0");
        rc(4'b0010, 32'd1, 32'd0, 1'b1, "gt_1_0");
        rc(4'b1110, 32'd1, 32'd0, 1'b0, "le_1_0");
        rc(4'b0011, 32'd0, 32'd1, 1'b1, "lt_0_1");
        rc(4'b0101, 32'd0, 32'd1, 1'b0, "ge_0_1");

        // Signedness
        rc(4'b0011, 32'hFFFF_FFFF, 32'd1, 1'b1, "lt_m1_1");
        rc(4'b0010, 32'hFFFF_FFFF, 32'd1, 1'b0, "gt_m1_1");
        rc(4'b0011, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, "lt_min_max");
        rc(4'b0010, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, "gt_max_min");
        rc(4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "le_min_m1");

        // Carry conditions
        fc(4'b0110, 0, 0, 1, 0, 1'b1, "hi_c1_z0");
        fc(4'b0111, 0, 0, 1, 0, 1'b1, "cs_c1");
        fc(4'b1000, 0, 0, 1, 0, 1'b0, "cc_c1");
        fc(4'b0110, 0, 0, 0, 0, 1'b0, "hi_c0_z0");
        fc(4'b0111, 0, 0, 0, 0, 1'b0, "cs_c0");
        fc(4'b1000, 0, 0, 0, 0, 1'b1, "cc_c0");
        fc(4'b0110, 0, 1, 1, 0, 1'b0, "hi_c1_z1");

        // N/V toggling every cycle, back-to-back
        fc(4'b1010, 1, 0, 0, 0, 1'b1, "mi_n1");
        fc(4'b1011, 0, 0, 0, 1, 1'b1, "pl_n0");
        fc(4'b1100, 1, 0, 0, 0, 1'b0, "vs_v0");
        fc(4'b1101, 0, 0, 0, 1, 1'b0, "vc_v1");
        fc(4'b1010, 0, 0, 0, 1, 1'b0, "mi_n0");
        fc(4'b1011, 1, 0, 0, 0, 1'b0, "pl_n1");
        fc(4'b1100, 0, 0, 0, 1, 1'b1, "vs_v1");
        fc(4'b1101, 1, 0, 0, 0, 1'b1, "vc_v0");

        // Mid-stream reset, then release captures inputs at the release edge
        apply(1'b1, 4'b1001, 0, 0, 0, 0, 32'h0, 32'h0, 1'b0, "midreset");
        apply(1'b0, 4'b0111, 0, 0, 1, 0, 32'h0, 32'h0, 1'b1, "midreset_release");

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (sb.size() > 0) begin
            tests++;
            failed++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
